// File: rtl/i2c_bus_conditioner.sv
// SCL/SDA input conditioning for the I2C master: synchronise, deglitch, detect
// START/STOP, track bus ownership and flag SCL held low for too long.
module i2c_bus_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pad_scl_i,
  input  logic                 pad_sda_i,
  output logic                 scl_f,
  output logic                 sda_f,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 stuck_clr,
  output logic                 start_det,
  output logic                 stop_det,
  output logic                 bus_busy,
  output logic                 scl_stuck
);

  localparam int              CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

  // Bit 0 carries SCL, bit 1 carries SDA through identical conditioning.
  logic [1:0] pad_in;
  logic [1:0] line_s;
  logic [1:0] line_f;

  assign pad_in = {pad_sda_i, pad_scl_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CW-1:0]          cnt_reg;
      logic                   f_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '1;
          cnt_reg  <= '0;
          f_reg    <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_in[gi]};
          // The output only moves after FILTER_LEN mismatches in a row.
          if (line_s[gi] != f_reg) begin
            if (cnt_reg == CNT_LAST) begin
              f_reg   <= line_s[gi];
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign line_s[gi] = sync_reg[SYNC_STAGES-1];
      assign line_f[gi] = f_reg;
    end
  endgenerate

  assign scl_f = line_f[0];
  assign sda_f = line_f[1];

  logic                 scl_q_reg;
  logic                 sda_q_reg;
  logic                 start_reg;
  logic                 stop_reg;
  logic                 busy_reg;
  logic                 stuck_reg;
  logic [TIMEOUT_W-1:0] tcnt_reg;

  logic                 start_next;
  logic                 stop_next;
  logic                 stuck_set;
  logic                 tcnt_run;
  logic [TIMEOUT_W:0]   tcnt_inc;

  always_comb begin
    start_next = sda_q_reg & ~sda_f & scl_q_reg & scl_f;
    stop_next  = ~sda_q_reg & sda_f & scl_q_reg & scl_f;
    tcnt_run   = ~scl_f & (timeout_limit != '0) & ~stuck_reg;
    tcnt_inc   = {1'b0, tcnt_reg} + {{TIMEOUT_W{1'b0}}, 1'b1};
    // >= so that lowering the limit below the running count trips at once.
    stuck_set  = tcnt_run & ~stuck_clr & (tcnt_inc >= {1'b0, timeout_limit});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q_reg <= 1'b1;
      sda_q_reg <= 1'b1;
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      scl_q_reg <= scl_f;
      sda_q_reg <= sda_f;
      start_reg <= start_next;
      stop_reg  <= stop_next;
      if (start_next) begin
        busy_reg <= 1'b1;
      end else if (stop_next || stuck_set) begin
        busy_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_reg <= 1'b0;
      tcnt_reg  <= '0;
    end else if (stuck_clr) begin
      stuck_reg <= 1'b0;
      tcnt_reg  <= '0;
    end else if (scl_f) begin
      tcnt_reg  <= '0;
    end else if (tcnt_run) begin
      // Count never exceeds the old limit, so the increment cannot overflow.
      tcnt_reg  <= tcnt_inc[TIMEOUT_W-1:0];
      if (stuck_set) begin
        stuck_reg <= 1'b1;
      end
    end
  end

  assign start_det = start_reg;
  assign stop_det  = stop_reg;
  assign bus_busy  = busy_reg;
  assign scl_stuck = stuck_reg;

endmodule
